// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared types and constants for the display arbiter slice:
//                FSM state encoding, requester count, digit index width and
//                display data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int NUM_REQ = 2;   // number of display requesters
    localparam int DIGIT_W = 2;   // width of the active digit index
    localparam int DATA_W  = 16;  // 4 hex/BCD digits per value

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/disp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_arbiter_if
//  Description : Bundles the requester-side and display-side signals of
//                disp_arbiter.
//                master : arbiter view (drives grant and display outputs)
//                slave  : environment view (drives requests and values)
//                Requester side : req, data0, data1, hex_dec_in, sign_in, gnt
//                Display side   : data, hex_dec, sign, digit_sel, frame_tick
//                                 (+ blank when DISP_ARB_BLANK_EN is defined)
//  Revision    : 1.0 - initial release
// ============================================================================
interface disp_arbiter_if;
    import disp_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  data0;
    logic [DATA_W-1:0]  data1;
    logic [NUM_REQ-1:0] hex_dec_in;
    logic [NUM_REQ-1:0] sign_in;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  data;
    logic               hex_dec;
    logic               sign;
    logic [DIGIT_W-1:0] digit_sel;
    logic               frame_tick;
`ifdef DISP_ARB_BLANK_EN
    logic               blank;
`endif

    modport master (
        input  req, data0, data1, hex_dec_in, sign_in,
        output gnt, data, hex_dec, sign, digit_sel, frame_tick
`ifdef DISP_ARB_BLANK_EN
        , output blank
`endif
    );

    modport slave (
        output req, data0, data1, hex_dec_in, sign_in,
        input  gnt, data, hex_dec, sign, digit_sel, frame_tick
`ifdef DISP_ARB_BLANK_EN
        , input blank
`endif
    );

endinterface
`default_nettype wire

// File: rtl/disp_arbiter_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Display multiplex timing. A free-running prescaler produces
//                one digit tick every 2^DIV_W cycles; the digit index steps
//                0..3 on each tick and frame_tick marks the last tick of
//                digit 3 (end of a full scan frame).
//  Ports       : clk, rst (async, active-high)
//                o_digit_sel  - active digit index
//                o_frame_tick - one-cycle end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_timer
    import disp_pkg::*;
#(
    parameter int DIV_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    output logic [DIGIT_W-1:0] o_digit_sel,
    output logic               o_frame_tick
);

    logic [DIV_W-1:0]   r_presc;
    logic [DIGIT_W-1:0] r_digit;
    logic               w_tick;

    // Tick while the prescaler sits at all-ones; its natural overflow wraps it to 0.
    assign w_tick = &r_presc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
            if (w_tick) begin
                r_digit <= r_digit + DIGIT_W'(1);
            end
        end
    end

    assign o_digit_sel  = r_digit;
    assign o_frame_tick = w_tick && (&r_digit);

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : disp_arbiter
//  Description : Two-requester arbiter for a shared 4-digit multiplexed
//                display. Grants within one cycle from IDLE (round-robin on
//                ties), only changes the displayed value or owner at frame
//                boundaries, and holds a contested grant for HOLD_FRAMES
//                frames.
//  Ports       : clk, rst (async, active-high)
//                bus (disp_arbiter_if.master): requests/values in,
//                grant and display drive out.
//  Config      : DISP_ARB_BLANK_EN - adds bus.blank (1 while IDLE).
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int DIV_W       = 19,
    parameter int HOLD_FRAMES = 8
) (
    input  logic           clk,
    input  logic           rst,
    disp_arbiter_if.master bus
);

    localparam int c_hold_w = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_FRAMES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_gidx;        // index of the granted requester
    logic                w_gidx_nxt;
    logic                r_ptr;         // round-robin tie winner
    logic                w_ptr_nxt;
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [c_hold_w-1:0] w_hold_inc;
    logic                w_latch;
    logic                w_latch_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_hex_dec;
    logic                r_sign;
    logic                w_frame_tick;
    logic                w_own_req;
    logic                w_oth_req;
    logic                w_oidx;

    scan_timer #(
        .DIV_W (DIV_W)
    ) u_scan_timer (
        .clk          (clk),
        .rst          (rst),
        .o_digit_sel  (bus.digit_sel),
        .o_frame_tick (w_frame_tick)
    );

    assign w_oidx    = ~r_gidx;
    assign w_own_req = bus.req[r_gidx];
    assign w_oth_req = bus.req[w_oidx];

    // Frames completed by the owner including the one ending now, so a
    // contested grant passes on the HOLD_FRAMES-th frame_tick after grant.
    assign w_hold_inc = (r_hold == c_hold_max) ? r_hold : r_hold + c_hold_w'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_latch     = 1'b0;
        w_latch_idx = r_gidx;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = SHOW;
                    w_gidx_nxt  = (&bus.req) ? r_ptr : bus.req[1];
                    w_ptr_nxt   = ~w_gidx_nxt;
                    w_hold_nxt  = '0;
                    w_latch     = 1'b1;
                    w_latch_idx = w_gidx_nxt;
                end
            end
            SHOW: begin
                if (w_frame_tick) begin
                    if (w_oth_req && (!w_own_req || (w_hold_inc >= c_hold_max))) begin
                        w_gidx_nxt  = w_oidx;
                        w_ptr_nxt   = r_gidx;
                        w_hold_nxt  = '0;
                        w_latch     = 1'b1;
                        w_latch_idx = w_oidx;
                    end else if (!w_own_req) begin
                        w_state_nxt = IDLE;
                    end else begin
                        // Owner keeps the display; refresh its value at the frame edge.
                        w_hold_nxt  = w_hold_inc;
                        w_latch     = 1'b1;
                        w_latch_idx = r_gidx;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gidx    <= 1'b0;
            r_ptr     <= 1'b0;
            r_hold    <= '0;
            r_data    <= '0;
            r_hex_dec <= 1'b0;
            r_sign    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            if (w_latch) begin
                r_data    <= w_latch_idx ? bus.data1 : bus.data0;
                r_hex_dec <= bus.hex_dec_in[w_latch_idx];
                r_sign    <= bus.sign_in[w_latch_idx];
            end
        end
    end

    // Grant is decoded from state so it is one-hot in SHOW and zero in IDLE.
    assign bus.gnt        = (r_state == SHOW) ? (r_gidx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.data       = r_data;
    assign bus.hex_dec    = r_hex_dec;
    assign bus.sign       = r_sign;
    assign bus.frame_tick = w_frame_tick;
`ifdef DISP_ARB_BLANK_EN
    assign bus.blank      = (r_state == IDLE);
`endif

endmodule
`default_nettype wire

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter DIV_W, default 19: scan prescaler width; one digit tick every 2^DIV_W clk cycles.
REQ-002 Parameter HOLD_FRAMES, default 8: minimum full scan frames a grant is held before it may pass to the other requester.
REQ-003 clk  input  1  system clock; sole clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester display request; bit i belongs to requester i.
REQ-006 data0, data1  input  16 each  4-digit value from requester 0 / 1.
REQ-007 hex_dec_in, sign_in  input  2 each  per-requester format bits; bit i belongs to requester i.
REQ-008 gnt  output  2  one-hot grant, or all-zero when the display is idle.
REQ-009 data  output  16  value driven to the display decoder.
REQ-010 hex_dec, sign  output  1 each  format bits driven to the display decoder.
REQ-011 digit_sel  output  2  active digit index driven to the display decoder.
REQ-012 frame_tick  output  1  one-cycle pulse on the last tick of digit 3.

Function
REQ-013 Prescaler shall increment every clk; tick shall be 1 for one cycle when the prescaler equals all-ones, and it shall then wrap to 0.
REQ-014 digit_sel shall increment on tick and wrap from 3 to 0; frame_tick = tick AND digit_sel==3.
REQ-015 FSM states: IDLE, SHOW. In IDLE with req!=0, the block shall enter SHOW on the next clk edge, with gnt and the latched data/format of the winner; latency is 1 cycle and does not depend on tick.
REQ-016 Simultaneous requests in IDLE shall be resolved by a round-robin pointer; the pointer shall point to requester 0 after reset and shall move to the non-winner on every grant.
REQ-017 In SHOW, data/hex_dec/sign shall be re-latched from the granted requester only on frame_tick; the display shall not change mid-frame.
REQ-018 The hold counter shall clear on grant and increment on each frame_tick, saturating at HOLD_FRAMES.
REQ-019 On frame_tick with hold>=HOLD_FRAMES and the other requester's req=1, the grant shall switch to the other requester; hold shall clear and the new data shall be latched in the same cycle.
REQ-020 On frame_tick with the granted req=0: if the other req=1, the grant shall switch to it regardless of hold; otherwise gnt=0 and the FSM shall return to IDLE.
REQ-021 A req drop between frame_ticks shall have no effect until the next frame_tick.
REQ-022 gnt shall never have both bits set; gnt=0 if and only if the state is IDLE.

Reset
REQ-023 On rst: state=IDLE, gnt=0, data=0, hex_dec=0, sign=0, digit_sel=0, frame_tick=0, prescaler=0, hold=0, pointer=requester 0. Assertion mid-grant shall abort the grant immediately.

Configuration
REQ-024 Macro DISP_ARB_BLANK_EN defined: add output blank (1 bit); blank=1 in IDLE and 0 in SHOW; blank=1 on reset.
REQ-025 Macro DISP_ARB_BLANK_EN undefined: the blank port shall not exist; in IDLE, data/hex_dec/sign shall hold the last latched values.

Structure
REQ-026 Package disp_pkg shall hold the state enum (IDLE, SHOW), NUM_REQ=2 and the DIGIT_W=2 constant.
REQ-027 Sub-module scan_timer shall contain the prescaler, digit_sel, tick and frame_tick logic; the arbitration FSM shall remain in disp_arbiter.

Verification (DIV_W=2, HOLD_FRAMES=2; one frame = 16 clk)
REQ-028 rst then idle -> digit_sel sequence 0,1,2,3 changing every 4 clk; frame_tick every 16 clk; gnt=00.
REQ-029 req=11 in IDLE, data0=16'h00AB, data1=16'h1234 -> next cycle gnt=01 and data=16'h00AB; after 2 frame_ticks gnt=10 and data=16'h1234.
REQ-030 gnt=01, data0 changes 16'h00AB->16'h00CD mid-frame -> data stays 16'h00AB until the next frame_tick, then becomes 16'h00CD.
REQ-031 gnt=01, req drops to 00 after 1 frame -> at the next frame_tick gnt=00 and state IDLE (blank=1 with DISP_ARB_BLANK_EN).
REQ-032 gnt=10 with req=11, rst pulsed mid-frame -> outputs go to reset values asynchronously; after release, req=11 -> gnt=01.
